// File: rtl/approx_mult_sequencer_if.sv
// Operand/product handshake bundle for the approximate radix-4 multiplier sequencer.
// Latency: n/a (wires only). Backpressure: carried by in_ready / out_ready.
// master = upstream/downstream side, slave = sequencer side.
interface approx_mult_sequencer_if #(
    parameter int N = 24
);
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     multiplicand;
    logic [N-1:0]     multiplier;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [2*N-1:0]   product;
    logic             busy;

    modport master (
        output in_valid, multiplicand, multiplier, flush, out_ready,
        input  in_ready, out_valid, product, busy
    );

    modport slave (
        input  in_valid, multiplicand, multiplier, flush, out_ready,
        output in_ready, out_valid, product, busy
    );
endinterface

// File: rtl/approx_mult_sequencer.sv
// Row-serial approximate radix-4 multiplier: one partial-product row per cycle into a 2N-bit accumulator.
// Latency: out_valid rises N/2 cycles after accept; minimum period N/2+2 cycles.
// Backpressure: DONE holds product stable until out_ready; in_ready only in IDLE; flush aborts.
module approx_mult_sequencer #(
    parameter int N = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    approx_mult_sequencer_if.slave bus
);
    localparam int ROWS  = N / 2;
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [N-1:0]     a_q;
    logic [N-1:0]     b_q;
    logic [2*N-1:0]   acc;
    logic [2*N-1:0]   prod_q;
    logic [ROW_W-1:0] row;

    logic [2:0]       grp;
    logic             sel;
    logic [2*N-1:0]   pp;
    logic [2*N-1:0]   acc_nxt;
    logic             last_row;

    // Appending a zero below B supplies B[-1]=0, so grp = {B[2r+1], B[2r], B[2r-1]}.
    assign grp      = 3'({b_q, 1'b0} >> {row, 1'b0});
    assign sel      = (grp[1] ^ grp[2]) & grp[0];
    assign pp       = sel ? ({{N{a_q[N-1]}}, a_q} << {row, 1'b0}) : '0;
    assign acc_nxt  = acc + pp;
    assign last_row = (row == ROW_W'(ROWS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            a_q    <= '0;
            b_q    <= '0;
            acc    <= '0;
            prod_q <= '0;
            row    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    // flush outranks accept
                    if (!bus.flush && bus.in_valid) begin
                        a_q   <= bus.multiplicand;
                        b_q   <= bus.multiplier;
                        acc   <= '0;
                        row   <= '0;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (bus.flush) begin
                        state <= S_IDLE;
                    end else begin
                        acc <= acc_nxt;
                        if (last_row) begin
                            prod_q <= acc_nxt;
                            state  <= S_DONE;
                        end else begin
                            row <= row + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (bus.flush || bus.out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Outputs decode straight from state so an asynchronous reset shows at once.
    assign bus.in_ready  = (state == S_IDLE);
    assign bus.out_valid = (state == S_DONE);
    assign bus.busy      = (state != S_IDLE);
    assign bus.product   = prod_q;
endmodule

// File: tb/tb_approx_mult_sequencer.sv
// Bench for approx_mult_sequencer: directed corner cases plus random transactions
// checked against an arithmetic reference of the approximate radix-4 product.
module tb_approx_mult_sequencer;
    localparam int N    = 24;
    localparam int ROWS = N / 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [2*N-1:0] last_prod;

    approx_mult_sequencer_if #(.N(N)) bus ();

    approx_mult_sequencer #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Sum of selected rows: row r contributes A * 4^r when B[2r]!=B[2r+1] and B[2r-1]=1.
    function automatic logic [2*N-1:0] model(input logic [N-1:0] a, input logic [N-1:0] b);
        longint sum;
        longint av;
        sum = 0;
        av  = longint'($signed(a));
        for (int r = 0; r < ROWS; r++) begin
            bit bm1;
            bm1 = 1'b0;
            if (r > 0) bm1 = b[2*r-1];
            if ((b[2*r] != b[2*r+1]) && bm1)
                sum += av * (longint'(1) << (2 * r));
        end
        return sum[2*N-1:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag);
        int lat;
        lat = 0;
        while (!bus.out_valid && lat < 4 * ROWS) begin
            tick();
            lat++;
        end
        check(tag, 64'(lat), 64'(ROWS));
    endtask

    task automatic do_txn(input logic [N-1:0] a, input logic [N-1:0] b, input int stall);
        logic [2*N-1:0] exp;
        exp = model(a, b);
        bus.in_valid     = 1'b1;
        bus.multiplicand = a;
        bus.multiplier   = b;
        tick();
        bus.in_valid     = 1'b0;
        bus.multiplicand = N'($urandom);
        bus.multiplier   = N'($urandom);
        check("busy_after_accept", 64'(bus.busy), 64'(1));
        wait_valid("latency");
        check("product", 64'(bus.product), 64'(exp));
        for (int i = 0; i < stall; i++) begin
            tick();
            check("hold_valid", 64'(bus.out_valid), 64'(1));
            check("hold_product", 64'(bus.product), 64'(exp));
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("valid_drop", 64'(bus.out_valid), 64'(0));
        check("ready_idle", 64'(bus.in_ready), 64'(1));
        last_prod = exp;
    endtask

    initial begin
        bool_seen_init();
    end

    task automatic bool_seen_init();
        bus.in_valid     = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier   = '0;
        bus.flush        = 1'b0;
        bus.out_ready    = 1'b0;
    endtask

    initial begin
        bit seen;
        #12;
        check("rst_in_ready",  64'(bus.in_ready),  64'(1));
        check("rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("rst_busy",      64'(bus.busy),      64'(0));
        check("rst_product",   64'(bus.product),   64'(0));
        @(negedge clk);
        rst = 1'b0;
        tick();

        // single-row hit
        do_txn(N'(3), N'('h6), 0);
        check("single_row_12", 64'(bus.product), 64'd12);

        // asynchronous reset mid-RUN
        bus.in_valid     = 1'b1;
        bus.multiplicand = N'(5);
        bus.multiplier   = N'('h6);
        tick();
        bus.in_valid = 1'b0;
        repeat (4) tick();
        #2 rst = 1'b1;
        #1;
        check("midrun_in_ready",  64'(bus.in_ready),  64'(1));
        check("midrun_out_valid", 64'(bus.out_valid), 64'(0));
        check("midrun_busy",      64'(bus.busy),      64'(0));
        check("midrun_product",   64'(bus.product),   64'(0));
        @(negedge clk);
        rst = 1'b0;
        tick();
        do_txn(N'(5), N'('h6), 2);
        check("post_reset_20", 64'(bus.product), 64'd20);

        // multi-row negative
        do_txn(N'('hFFFFFF), N'('h66), 0);
        check("neg_m68", 64'(bus.product), 64'h0000_FFFF_FFFF_FFBC);

        // no-select patterns
        do_txn(N'('h123456), N'('hFFFFFF), 0);
        check("all_ones_zero", 64'(bus.product), 64'd0);
        do_txn(N'(7), N'('h1), 0);
        check("lsb_only_zero", 64'(bus.product), 64'd0);

        // backpressure, then back-to-back accept after the handshake
        bus.in_valid     = 1'b1;
        bus.multiplicand = N'(9);
        bus.multiplier   = N'('h66);
        tick();
        bus.in_valid = 1'b0;
        wait_valid("bp_latency");
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_valid",   64'(bus.out_valid), 64'(1));
            check("bp_product", 64'(bus.product),   64'(model(N'(9), N'('h66))));
        end
        bus.out_ready    = 1'b1;
        bus.in_valid     = 1'b1;
        bus.multiplicand = N'(3);
        bus.multiplier   = N'('h6);
        tick();
        bus.out_ready = 1'b0;
        check("b2b_valid_drop", 64'(bus.out_valid), 64'(0));
        check("b2b_idle",       64'(bus.in_ready),  64'(1));
        tick();
        bus.in_valid = 1'b0;
        check("b2b_busy",     64'(bus.busy),     64'(1));
        check("b2b_in_ready", 64'(bus.in_ready), 64'(0));
        wait_valid("b2b_latency");
        check("b2b_product", 64'(bus.product), 64'd12);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        last_prod = 48'd12;

        // flush at RUN row 5: nothing presented, product retained
        bus.in_valid     = 1'b1;
        bus.multiplicand = N'('h7FF);
        bus.multiplier   = N'('h666666);
        tick();
        bus.in_valid = 1'b0;
        repeat (5) tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("flush_in_ready",  64'(bus.in_ready),  64'(1));
        check("flush_busy",      64'(bus.busy),      64'(0));
        check("flush_out_valid", 64'(bus.out_valid), 64'(0));
        seen = 1'b0;
        repeat (ROWS + 2) begin
            tick();
            if (bus.out_valid) seen = 1'b1;
        end
        check("flush_never_valid", 64'(seen), 64'(0));
        check("flush_keeps_product", 64'(bus.product), 64'(last_prod));

        // flush in IDLE beats in_valid
        bus.flush        = 1'b1;
        bus.in_valid     = 1'b1;
        bus.multiplicand = N'(3);
        bus.multiplier   = N'('h6);
        tick();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        check("idle_flush_busy",  64'(bus.busy),     64'(0));
        check("idle_flush_ready", 64'(bus.in_ready), 64'(1));
        tick();
        check("idle_flush_busy2", 64'(bus.busy), 64'(0));

        // flush together with out_ready in DONE
        bus.in_valid     = 1'b1;
        bus.multiplicand = N'(11);
        bus.multiplier   = N'('h6);
        tick();
        bus.in_valid = 1'b0;
        wait_valid("done_flush_latency");
        bus.flush     = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        check("done_flush_valid", 64'(bus.out_valid), 64'(0));
        check("done_flush_ready", 64'(bus.in_ready),  64'(1));

        // random transactions
        repeat (40) begin
            do_txn(N'($urandom), N'($urandom), int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
